// File: rtl/rat_stack_pkg.sv
// Shared types and default sizes for the RAT CPU return stack.
// Imported by the stack top and its storage array.
package rat_stack_pkg;

    localparam int RAT_ADDR_W         = 10;
    localparam int RAT_STK_DEPTH_LOG2 = 5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD
    } stk_state_t;

endpackage

// File: rtl/stack_ram.sv
// Return-address storage: synchronous write, registered read.
// The array itself is never reset; entries above SP are don't-care.
module stack_ram #(
    parameter int ADDR_W     = 10,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [ADDR_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [ADDR_W-1:0]     rdata
);

    logic [ADDR_W-1:0] mem [2**DEPTH_LOG2];

    // Write on enable; read address is always sampled, one-cycle latency.
    always_ff @(posedge CLK) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pc_return_stack.sv
// Call/return address stack feeding the PC load path.
// CALL pushes PC+1; RET pops it and strobes RET_LD two cycles later.
module pc_return_stack
    import rat_stack_pkg::*;
#(
    parameter int ADDR_W     = RAT_ADDR_W,
    parameter int DEPTH_LOG2 = RAT_STK_DEPTH_LOG2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_W-1:0]     PC_COUNT,
    input  logic                  CALL,
    input  logic                  RET,
    input  logic                  CLR_ERR,
    output logic [ADDR_W-1:0]     RET_ADDR,
    output logic                  RET_LD,
    output logic                  BUSY,
    output logic [DEPTH_LOG2:0]   DEPTH,
    output logic                  OVF,
    output logic                  UDF,
    output logic                  COLL
);

    stk_state_t state, state_nx;

    logic [DEPTH_LOG2:0]   sp;
    logic [DEPTH_LOG2-1:0] waddr, raddr;
    logic [ADDR_W-1:0]     wdata, rdata;
    logic idle, full, empty;
    logic do_push, do_pop;
    logic ovf_set, udf_set, coll_set;
    logic busy_nx, ld_nx;

    assign idle  = (state == IDLE);
    assign full  = sp[DEPTH_LOG2];
    assign empty = (sp == '0);

    assign do_push  = idle & CALL & ~RET & ~full;
    assign do_pop   = idle & RET & ~CALL & ~empty;
    assign ovf_set  = idle & CALL & ~RET & full;
    assign udf_set  = idle & RET & ~CALL & empty;
    assign coll_set = idle & CALL & RET;

    assign waddr = sp[DEPTH_LOG2-1:0];
    assign raddr = sp[DEPTH_LOG2-1:0] - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    assign wdata = PC_COUNT + {{(ADDR_W-1){1'b0}}, 1'b1};

    assign DEPTH = sp;

    stack_ram #(
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .CLK   (CLK),
        .we    (do_push),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // State register; reset aborts any pop in flight.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: a pop walks IDLE -> READ -> LOAD -> IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (do_pop) state_nx = READ;
            READ:    state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from next state so the strobes can be registered.
    always_comb begin
        busy_nx = (state_nx != IDLE);
        ld_nx   = (state_nx == LOAD);
    end

    // Registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BUSY   <= 1'b0;
            RET_LD <= 1'b0;
        end else begin
            BUSY   <= busy_nx;
            RET_LD <= ld_nx;
        end
    end

    // Stack pointer doubles as the entry count.
    always_ff @(posedge CLK) begin
        if (RST)
            sp <= '0;
        else if (do_push)
            sp <= sp + 1'b1;
        else if (do_pop)
            sp <= sp - 1'b1;
    end

    // Capture the popped word; held until the next pop.
    always_ff @(posedge CLK) begin
        if (RST)
            RET_ADDR <= '0;
        else if (state == READ)
            RET_ADDR <= rdata;
    end

    // Sticky error flags; a new error beats a same-edge clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVF  <= 1'b0;
            UDF  <= 1'b0;
            COLL <= 1'b0;
        end else begin
            OVF  <= (OVF  & ~CLR_ERR) | ovf_set;
            UDF  <= (UDF  & ~CLR_ERR) | udf_set;
            COLL <= (COLL & ~CLR_ERR) | coll_set;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed and random checks of pc_return_stack against a
// queue-based model of a LIFO with a fixed two-cycle pop latency.
module tb_pc_return_stack;

    localparam int AW  = 10;
    localparam int DL  = 5;
    localparam int CAP = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] PC_COUNT = '0;
    logic          CALL = 1'b0;
    logic          RET = 1'b0;
    logic          CLR_ERR = 1'b0;
    logic [AW-1:0] RET_ADDR;
    logic          RET_LD;
    logic          BUSY;
    logic [DL:0]   DEPTH;
    logic          OVF;
    logic          UDF;
    logic          COLL;

    pc_return_stack #(.ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PC_COUNT (PC_COUNT),
        .CALL     (CALL),
        .RET      (RET),
        .CLR_ERR  (CLR_ERR),
        .RET_ADDR (RET_ADDR),
        .RET_LD   (RET_LD),
        .BUSY     (BUSY),
        .DEPTH    (DEPTH),
        .OVF      (OVF),
        .UDF      (UDF),
        .COLL     (COLL)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of return addresses, plus a
    // countdown of cycles left until the popped value is presented.
    logic [AW-1:0] stk[$];
    int            pop_wait = 0;
    logic [AW-1:0] pend = '0;
    logic [AW-1:0] m_ra = '0;
    logic          m_ovf = 0, m_udf = 0, m_coll = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic c, input logic r,
                              input logic clr, input logic rs,
                              input logic [AW-1:0] pc);
        if (rs) begin
            stk.delete();
            pop_wait = 0;
            m_ra = '0;
            m_ovf = 0; m_udf = 0; m_coll = 0;
        end else begin
            if (clr) begin
                m_ovf = 0; m_udf = 0; m_coll = 0;
            end
            if (pop_wait == 2) begin
                pop_wait = 1;
                m_ra = pend;
            end else if (pop_wait == 1) begin
                pop_wait = 0;
            end else if (c && r) begin
                m_coll = 1;
            end else if (c) begin
                if (stk.size() == CAP) m_ovf = 1;
                else stk.push_back(AW'(pc + 1));
            end else if (r) begin
                if (stk.size() == 0) m_udf = 1;
                else begin
                    pend = stk.pop_back();
                    pop_wait = 2;
                end
            end
        end
    endtask

    task automatic cyc(input logic c, input logic r, input logic clr,
                       input logic rs, input logic [AW-1:0] pc);
        CALL = c; RET = r; CLR_ERR = clr; RST = rs; PC_COUNT = pc;
        @(posedge CLK);
        model_edge(c, r, clr, rs, pc);
        #1;
        chk("depth",    32'(DEPTH),    32'(stk.size()));
        chk("busy",     32'(BUSY),     32'(pop_wait != 0));
        chk("ret_ld",   32'(RET_LD),   32'(pop_wait == 1));
        chk("ret_addr", 32'(RET_ADDR), 32'(m_ra));
        chk("ovf",      32'(OVF),      32'(m_ovf));
        chk("udf",      32'(UDF),      32'(m_udf));
        chk("coll",     32'(COLL),     32'(m_coll));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0);
    endtask

    task automatic push(input logic [AW-1:0] pc);
        cyc(1, 0, 0, 0, pc);
    endtask

    task automatic pop3();
        cyc(0, 1, 0, 0, '0);
        idle(3);
    endtask

    initial begin
        // Reset, then single call/return
        cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);
        chk("rst_depth", 32'(DEPTH), 32'd0);
        push(10'h01A);
        chk("call_depth", 32'(DEPTH), 32'd1);
        cyc(0, 1, 0, 0, '0);
        chk("busy1", 32'(BUSY), 32'd1);
        idle(1);
        chk("ld_pulse", 32'(RET_LD), 32'd1);
        chk("ld_addr", 32'(RET_ADDR), 32'h01B);
        idle(1);
        chk("ld_done", 32'(RET_LD), 32'd0);
        idle(1);

        // Nesting
        push(10'h010); push(10'h020); push(10'h030);
        pop3(); pop3(); pop3();
        chk("nest_ra", 32'(RET_ADDR), 32'h011);

        // Wrap of PC+1
        push(10'h3FF);
        cyc(0, 1, 0, 0, '0);
        idle(1);
        chk("wrap_addr", 32'(RET_ADDR), 32'h000);
        idle(2);

        // Fill, overflow, top entry intact
        for (int i = 0; i < CAP; i++) push(AW'(i * 7 + 3));
        push(10'h155);
        chk("ovf_set", 32'(OVF), 32'd1);
        chk("full_depth", 32'(DEPTH), 32'd32);
        cyc(0, 1, 0, 0, '0);
        idle(1);
        chk("top_kept", 32'(RET_ADDR), 32'((31 * 7 + 3) + 1));
        idle(2);
        cyc(0, 0, 1, 0, '0);
        for (int i = 0; i < CAP - 1; i++) pop3();

        // Empty pop and collision
        cyc(0, 1, 0, 0, '0);
        chk("udf_set", 32'(UDF), 32'd1);
        idle(2);
        cyc(1, 1, 0, 0, 10'h050);
        chk("coll_set", 32'(COLL), 32'd1);
        cyc(0, 0, 1, 0, '0);
        chk("clr_all", 32'({OVF, UDF, COLL}), 32'd0);

        // Call during READ is ignored
        push(10'h100);
        cyc(0, 1, 0, 0, '0);
        cyc(1, 0, 0, 0, 10'h222);
        idle(3);
        chk("busy_ign", 32'(DEPTH), 32'd0);

        // Reset during READ aborts the pop
        push(10'h200);
        push(10'h201);
        cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 0, 1, '0);
        idle(3);
        chk("rst_abort", 32'(RET_ADDR), 32'd0);

        // Clear and overflow on the same edge
        for (int i = 0; i < CAP; i++) push(AW'($urandom));
        cyc(1, 0, 1, 0, 10'h0AA);
        chk("set_wins", 32'(OVF), 32'd1);
        cyc(0, 0, 0, 1, '0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            cyc(r < 45, (r >= 35 && r < 75), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 199) == 0), AW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
